// File: rtl/regfile_wport_sched.sv
// Write-port scheduler sharing the register-file write port between WB (A) and the MDU FIFO (B).
// Optional starvation aging of the FIFO head is enabled by defining REGSCHED_AGE_EN.
module regfile_wport_sched #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_reg,
    input  logic [31:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_reg,
    input  logic [31:0]              b_data,
    output logic                     we,
    output logic [4:0]               writeReg,
    output logic [31:0]              Din,
    output logic [31:0]              b_pend,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]    reg_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic full, nonempty, aged, grant_a, grant_b, push, pop;

`ifdef REGSCHED_AGE_EN
    logic [3:0] age_q, age_d;

    assign aged = (age_q >= 4'(STARVE_LIMIT));

    always_comb begin
        age_d = age_q;
        if (pop) begin
            age_d = '0;
        end else if (nonempty && !grant_b && age_q != 4'hf) begin
            age_d = age_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign aged = 1'b0;
`endif

    // Grants are gated by rst_n so every handshake and write stays quiet during reset.
    always_comb begin
        full     = (cnt_q == Full);
        nonempty = (cnt_q != '0);
        grant_b  = rst_n && nonempty && (!a_valid || full || aged);
        grant_a  = rst_n && a_valid && !grant_b;
        a_ready  = grant_a;
        b_ready  = rst_n && (!full || grant_b);
        push     = b_valid && b_ready;
        pop      = grant_b;

        writeReg = '0;
        Din      = '0;
        if (grant_a) begin
            writeReg = a_reg;
            Din      = a_data;
        end else if (grant_b) begin
            writeReg = reg_q[rd_ptr_q];
            Din      = data_q[rd_ptr_q];
        end
        we = (grant_a || grant_b) && (writeReg != 5'd0);
    end

    always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        b_pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr_q} < cnt_q) begin
                b_pend = b_pend | (32'd1 << reg_q[i]);
            end
        end
        b_pend[0] = 1'b0;
    end

    assign fifo_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= b_reg;
            data_q[wr_ptr_q] <= b_data;
        end
    end

endmodule

// File: doc/regfile_wport_sched.md
# regfile_wport_sched

Write-port scheduler for the single-write-port register file. Shares the one write port (`we`, `writeReg`, `Din`) between the in-order pipeline writeback stage (requester A) and the multi-cycle multiply/divide unit (requester B). B's results are buffered in a small FIFO. A per-register pending mask lets the hazard unit stall readers of registers whose writes are still queued. It sits between the WB stage / MDU and the register file. The register file captures its write port on the falling edge of `clk`.

## Interface
Parameters:
- `DEPTH`, 2: B FIFO entries. Legal values are 2, 4 or 8.
- `STARVE_LIMIT`, 4: number of cycles B's head entry may wait before aging priority applies. Range 1..15. Used only with `REGSCHED_AGE_EN`.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `a_valid`  in  1: WB stage has a result.
- `a_ready`  out  1: WB result accepted this cycle. WB stalls while `a_valid && !a_ready`.
- `a_reg`  in  5: destination register for A.
- `a_data`  in  32: write data for A.
- `b_valid`  in  1: MDU has a result.
- `b_ready`  out  1: MDU result enqueued this cycle.
- `b_reg`  in  5: destination register for B.
- `b_data`  in  32: write data for B.
- `we`  out  1: register-file write enable.
- `writeReg`  out  5: register-file write address.
- `Din`  out  32: register-file write data.
- `b_pend`  out  32: bit r is set when the FIFO holds a write to register r. Bit 0 is always 0.
- `fifo_cnt`  out  $clog2(DEPTH)+1: current number of FIFO occupants.

## Operation
- FIFO state: `cnt`, read pointer, write pointer, and per-entry {reg, data}. Pointers wrap modulo `DEPTH`.
- Grant logic (combinational) for B, active only while `cnt>0`:
  - `grantB = !a_valid || cnt==DEPTH || aged`.
  - `aged` = (`age >= STARVE_LIMIT`) with `REGSCHED_AGE_EN`, otherwise 0.
- Grant logic for A: `grantA = a_valid && !grantB`.
- Handshake outputs:
  - `a_ready = grantA`.
  - `b_ready = (cnt<DEPTH) || grantB`. When full, a same-cycle pop and push is allowed.
- Write port:
  - On grantA: `writeReg=a_reg`, `Din=a_data`.
  - On grantB: `writeReg`/`Din` are taken from the FIFO head.
  - No grant: `writeReg=0`, `Din=0`, `we=0`.
  - `we = (grantA||grantB) && writeReg!=0`. A write to $0 still completes its handshake and pops or acks normally, but is never written.
- FIFO update at posedge:
  - Push on `b_valid && b_ready`.
  - Pop on grantB.
  - Simultaneous push and pop leaves `cnt` unchanged.
- No B bypass: a B result pushed into an empty FIFO is written no earlier than the next cycle.
- `b_pend`: OR of decoded `reg` over all valid entries, recomputed from the FIFO contents. Duplicate destinations are allowed, and the bit clears only when the last matching entry pops.
- Ordering: B entries are written in FIFO order. There is no ordering guarantee between A and B writes to the same register. Hazard control uses `b_pend` to prevent that case.

## Timing
- Grant, `a_ready`, `b_ready`, `we`, `writeReg` and `Din` are combinational from inputs and state in the same cycle. They must settle before the falling edge of `clk`.
- A latency is 0 cycles: the write happens in the handshake cycle.
- B latency is at least 1 cycle from push to write.
- `rst_n` low at a rising edge:
  - `cnt`=0, pointers=0, `age`=0.
  - Every queued entry is discarded, including when reset lands mid-operation.
- While `rst_n` is low, `a_ready`, `b_ready` and `we` are forced to 0 and `writeReg`/`Din` are forced to 0.
- After reset releases, the first cycle shows `b_pend=0` and `fifo_cnt=0`.
- Full FIFO with `a_valid` asserted: B wins and `a_ready`=0 for that cycle. A resumes once `cnt<DEPTH`.

## Configuration
- `REGSCHED_AGE_EN`, when defined:
  - A 4-bit `age` counter increments each cycle in which `cnt>0` and B is not granted.
  - The counter saturates at 15 and clears on every pop and on reset.
  - When `age >= STARVE_LIMIT`, B is granted over a valid A.
- `REGSCHED_AGE_EN` undefined: no counter exists, and B wins only when A is idle or the FIFO is full. The full-FIFO rule still bounds B's wait.

## Test plan
- Reset mid-operation: fill the FIFO (`DEPTH`=2) with writes to r5 and r6, then assert `rst_n`=0 for one edge. Expected: `fifo_cnt`=0, `b_pend`=0, no writes to r5 or r6 afterwards, and `we`=0 while in reset.
- A only: `a_valid`=1, `a_reg`=8, `a_data`=0xDEADBEEF, FIFO empty. Expected: `a_ready`=1, `we`=1, `writeReg`=8, `Din`=0xDEADBEEF in the same cycle, and r8 reads 0xDEADBEEF after the falling edge.
- B deferred behind A:
  - Stimulus: cycle 0, B pushes r9=0x11; `a_valid` stays 1 for 3 cycles (r10..r12).
  - Expected without the macro: A writes r10..r12 in cycles 0..2; `b_pend[9]`=1 in cycles 1..3; r9=0x11 is written in cycle 3 once A drops.
- Full FIFO override:
  - Stimulus: `DEPTH`=2 with both entries filled (r3, r4); `a_valid`=1; B pushes r7 in the same cycle.
  - Expected: `a_ready`=0, r3 written, `b_ready`=1, `fifo_cnt` stays 2, and `b_pend` changes from {3,4} to {4,7}.
- $0 suppression: B pushes `b_reg`=0, `b_data`=0xFFFF with A idle. Expected: the pop occurs the next cycle with `we`=0, and `b_pend`=0 throughout.
- Aging with `REGSCHED_AGE_EN` and `STARVE_LIMIT`=4:
  - Stimulus: one B entry (r2) and continuous `a_valid`.
  - Expected: A is granted for 4 cycles, then B writes r2 in the 5th cycle with `a_ready`=0 for exactly that cycle.
